// File: rtl/link_table_pkg.sv
// Shared types and constants for the linked-list page manager.
package link_table_pkg;

   localparam int unsigned PAGE_NUM_LOG_DEF = 6;
   localparam int unsigned CH_NUM_LOG_DEF   = 2;

   typedef logic [PAGE_NUM_LOG_DEF-1:0] page_t;
   typedef logic [CH_NUM_LOG_DEF-1:0]   ch_t;

   localparam int unsigned ERR_W           = 3;
   localparam int unsigned ERR_DOUBLE_FREE = 0;
   localparam int unsigned ERR_RD_EMPTY    = 1;
   localparam int unsigned ERR_WR_FULL     = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/link_table_next_ram.sv
// Next-pointer array: one write port, two combinational read ports.
module link_table_next_ram
   import link_table_pkg::*;
#(
   parameter int unsigned PAGE_NUM_LOG = PAGE_NUM_LOG_DEF
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [PAGE_NUM_LOG-1:0] waddr,
   input  logic [PAGE_NUM_LOG-1:0] wdata,
   input  logic [PAGE_NUM_LOG-1:0] raddr_a,
   output logic [PAGE_NUM_LOG-1:0] rdata_a,
   input  logic [PAGE_NUM_LOG-1:0] raddr_b,
   output logic [PAGE_NUM_LOG-1:0] rdata_b
);

   localparam int unsigned PAGE_NUM = 1 << PAGE_NUM_LOG;

   logic [PAGE_NUM_LOG-1:0] mem [PAGE_NUM];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/link_table_manager.sv
// Free-page stack plus per-channel FIFO page lists sharing one next-pointer array.
// Optional sticky error reporting is built when LINK_TABLE_ERR_EN is defined.
module link_table_manager
   import link_table_pkg::*;
#(
   parameter int unsigned PAGE_NUM_LOG = PAGE_NUM_LOG_DEF,
   parameter int unsigned CH_NUM       = 4,
   parameter int unsigned CH_NUM_LOG   = CH_NUM_LOG_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    init_done,
   input  logic                    wr_req,
   input  logic [CH_NUM_LOG-1:0]   wr_ch,
   output logic                    wr_ack,
   output logic [PAGE_NUM_LOG-1:0] wr_addr,
   input  logic                    rd_req,
   input  logic [CH_NUM_LOG-1:0]   rd_ch,
   output logic                    rd_ack,
   output logic [PAGE_NUM_LOG-1:0] rd_addr,
   output logic                    rd_last,
   input  logic                    free_req,
   input  logic [PAGE_NUM_LOG-1:0] free_addr,
   output logic                    free_ack,
   output logic [CH_NUM-1:0]       ch_empty,
   output logic                    free_empty,
   output logic [PAGE_NUM_LOG:0]   free_count,
   output logic [ERR_W-1:0]        err
);

   localparam int unsigned PAGE_NUM = 1 << PAGE_NUM_LOG;
   localparam logic [PAGE_NUM_LOG-1:0] IDX_LAST   = PAGE_NUM_LOG'(PAGE_NUM - 1);
   localparam logic [PAGE_NUM_LOG:0]   FULL_COUNT = (PAGE_NUM_LOG+1)'(PAGE_NUM);

   state_t                  state_q, state_d;
   logic [PAGE_NUM_LOG-1:0] init_idx;
   logic [PAGE_NUM_LOG-1:0] free_head;
   logic [PAGE_NUM_LOG:0]   free_count_q;
   logic [PAGE_NUM_LOG-1:0] head [CH_NUM];
   logic [PAGE_NUM_LOG-1:0] tail [CH_NUM];
   logic [CH_NUM-1:0]       ch_empty_q;

   logic                    ram_we;
   logic [PAGE_NUM_LOG-1:0] ram_waddr, ram_wdata;
   logic [PAGE_NUM_LOG-1:0] free_next, head_next;
   logic                    double_free, free_commit;

   link_table_next_ram #(.PAGE_NUM_LOG(PAGE_NUM_LOG)) u_next_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr_a (free_head),
      .rdata_a (free_next),
      .raddr_b (head[rd_ch]),
      .rdata_b (head_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      free_ack = 1'b0;
      rd_ack   = 1'b0;
      wr_ack   = 1'b0;
      unique case (state_q)
         ST_INIT: if (init_idx == IDX_LAST) state_d = ST_RUN;
         ST_RUN: begin
            free_ack = free_req;
            rd_ack   = rd_req & ~free_req & ~ch_empty_q[rd_ch];
            wr_ack   = wr_req & ~free_req & ~rd_ack & ~free_empty;
         end
      endcase
   end

   assign init_done   = (state_q == ST_RUN);
   assign free_empty  = (free_count_q == '0);
   assign free_count  = free_count_q;
   assign ch_empty    = ch_empty_q;
   assign wr_addr     = free_head;
   assign rd_addr     = head[rd_ch];
   assign rd_last     = rd_ack & (head[rd_ch] == tail[rd_ch]);
   assign double_free = (free_count_q == FULL_COUNT);
   assign free_commit = free_ack & ~double_free;

   // Ops are mutually exclusive, so a single write port covers init, free and append.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = init_idx;
      ram_wdata = init_idx + PAGE_NUM_LOG'(1);
      if (state_q == ST_INIT) begin
         ram_we = 1'b1;
      end else if (free_commit) begin
         ram_we    = 1'b1;
         ram_waddr = free_addr;
         ram_wdata = free_head;
      end else if (wr_ack && !ch_empty_q[wr_ch]) begin
         ram_we    = 1'b1;
         ram_waddr = tail[wr_ch];
         ram_wdata = free_head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_idx     <= '0;
         free_head    <= '0;
         free_count_q <= '0;
         ch_empty_q   <= '1;
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            head[i] <= '0;
            tail[i] <= '0;
         end
      end else begin
         if (state_q == ST_INIT) begin
            init_idx <= init_idx + PAGE_NUM_LOG'(1);
            if (init_idx == IDX_LAST) begin
               free_head    <= '0;
               free_count_q <= FULL_COUNT;
            end
         end
         if (free_commit) begin
            free_head    <= free_addr;
            free_count_q <= free_count_q + (PAGE_NUM_LOG+1)'(1);
         end
         if (rd_ack) begin
            if (rd_last) ch_empty_q[rd_ch] <= 1'b1;
            else         head[rd_ch]       <= head_next;
         end
         if (wr_ack) begin
            free_head    <= free_next;
            free_count_q <= free_count_q - (PAGE_NUM_LOG+1)'(1);
            tail[wr_ch]  <= free_head;
            if (ch_empty_q[wr_ch]) begin
               head[wr_ch]       <= free_head;
               ch_empty_q[wr_ch] <= 1'b0;
            end
         end
      end
   end

`ifdef LINK_TABLE_ERR_EN
   logic [ERR_W-1:0] err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else if (state_q == ST_RUN) begin
         if (free_ack && double_free)                      err_q[ERR_DOUBLE_FREE] <= 1'b1;
         if (rd_req && !free_req && ch_empty_q[rd_ch])     err_q[ERR_RD_EMPTY]    <= 1'b1;
         if (wr_req && free_empty && !free_ack && !rd_ack) err_q[ERR_WR_FULL]     <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = '0;
`endif

endmodule

// File: tb/tb_link_table_manager.sv
// Randomized bench for link_table_manager against a queue-based model of the page lists.
module tb_link_table_manager;

   localparam int PAGE_NUM_LOG = 6;
   localparam int CH_NUM       = 4;
   localparam int CH_NUM_LOG   = 2;
   localparam int PAGE_NUM     = 64;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    init_done;
   logic                    wr_req, rd_req, free_req;
   logic [CH_NUM_LOG-1:0]   wr_ch, rd_ch;
   logic                    wr_ack, rd_ack, free_ack, rd_last;
   logic [PAGE_NUM_LOG-1:0] wr_addr, rd_addr, free_addr;
   logic [CH_NUM-1:0]       ch_empty;
   logic                    free_empty;
   logic [PAGE_NUM_LOG:0]   free_count;
   logic [2:0]              err;

   always #5 clk = ~clk;

   link_table_manager #(
      .PAGE_NUM_LOG (PAGE_NUM_LOG),
      .CH_NUM       (CH_NUM),
      .CH_NUM_LOG   (CH_NUM_LOG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .init_done  (init_done),
      .wr_req     (wr_req),
      .wr_ch      (wr_ch),
      .wr_ack     (wr_ack),
      .wr_addr    (wr_addr),
      .rd_req     (rd_req),
      .rd_ch      (rd_ch),
      .rd_ack     (rd_ack),
      .rd_addr    (rd_addr),
      .rd_last    (rd_last),
      .free_req   (free_req),
      .free_addr  (free_addr),
      .free_ack   (free_ack),
      .ch_empty   (ch_empty),
      .free_empty (free_empty),
      .free_count (free_count),
      .err        (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: free stack (front = next page handed out), per-channel FIFOs, pages held by the controller.
   int         free_q [$];
   int         ch_q [CH_NUM][$];
   int         owned [$];
   logic [2:0] m_err;

   logic [PAGE_NUM_LOG-1:0] last_wr_addr, last_rd_addr;
   logic                    last_free_ack, last_rd_ack, last_wr_ack, last_rd_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CH_NUM-1:0] model_ch_empty();
      logic [CH_NUM-1:0] e;
      for (int c = 0; c < CH_NUM; c++) e[c] = (ch_q[c].size() == 0);
      return e;
   endfunction

   function automatic logic [2:0] model_err();
`ifdef LINK_TABLE_ERR_EN
      return m_err;
`else
      return 3'b000;
`endif
   endfunction

   task automatic model_reset();
      free_q.delete();
      for (int p = 0; p < PAGE_NUM; p++) free_q.push_back(p);
      for (int c = 0; c < CH_NUM; c++) ch_q[c].delete();
      owned.delete();
      m_err = 3'b000;
   endtask

   task automatic step(input bit fr, input int fa, input bit rr, input int rc,
                       input bit wr, input int wc);
      bit e_rd, e_wr;
      free_req  = fr;
      free_addr = PAGE_NUM_LOG'(fa);
      rd_req    = rr;
      rd_ch     = CH_NUM_LOG'(rc);
      wr_req    = wr;
      wr_ch     = CH_NUM_LOG'(wc);
      @(negedge clk);
      e_rd = rr && !fr && (ch_q[rc].size() > 0);
      e_wr = wr && !fr && !e_rd && (free_q.size() > 0);
      check("free_ack", 32'(free_ack), 32'(fr));
      check("rd_ack", 32'(rd_ack), 32'(e_rd));
      check("wr_ack", 32'(wr_ack), 32'(e_wr));
      if (e_rd) begin
         check("rd_addr", 32'(rd_addr), ch_q[rc][0]);
         check("rd_last", 32'(rd_last), 32'(ch_q[rc].size() == 1));
      end
      if (e_wr) check("wr_addr", 32'(wr_addr), free_q[0]);
      check("free_count", 32'(free_count), free_q.size());
      check("free_empty", 32'(free_empty), 32'(free_q.size() == 0));
      check("ch_empty", 32'(ch_empty), 32'(model_ch_empty()));
      check("err", 32'(err), 32'(model_err()));
      last_free_ack = free_ack;
      last_rd_ack   = rd_ack;
      last_wr_ack   = wr_ack;
      last_rd_addr  = rd_addr;
      last_rd_last  = rd_last;
      last_wr_addr  = wr_addr;
      if (rr && !fr && ch_q[rc].size() == 0) m_err[1] = 1'b1;
      if (wr && !fr && !e_rd && free_q.size() == 0) m_err[2] = 1'b1;
      if (fr) begin
         if (free_q.size() == PAGE_NUM) begin
            m_err[0] = 1'b1;
         end else begin
            free_q.push_front(fa);
            for (int i = 0; i < owned.size(); i++)
               if (owned[i] == fa) begin
                  owned.delete(i);
                  break;
               end
         end
      end else if (e_rd) begin
         owned.push_back(ch_q[rc].pop_front());
      end else if (e_wr) begin
         ch_q[wc].push_back(free_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (!init_done) check("init_acks", 32'({free_ack, rd_ack, wr_ack}), 32'd0);
      end
      check("init_latency", n, 64);
      free_req = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      check("init_free_count", 32'(free_count), 32'd64);
      check("init_ch_empty", 32'(ch_empty), 32'hF);
      check("init_err", 32'(err), 32'd0);
      model_reset();
   endtask

   task automatic drain();
      for (int c = 0; c < CH_NUM; c++)
         while (ch_q[c].size() > 0) step(0, 0, 1, c, 0, 0);
      while (owned.size() > 0) step(1, owned[0], 0, 0, 0, 0);
   endtask

   initial begin
      bit fr, rr, wr;
      int fa, rc, wc, pg;

      rst       = 1'b1;
      free_req  = 1'b1;
      free_addr = '0;
      rd_req    = 1'b1;
      rd_ch     = '0;
      wr_req    = 1'b1;
      wr_ch     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_free_count", 32'(free_count), 32'd0);
      check("rst_free_empty", 32'(free_empty), 32'd1);
      check("rst_ch_empty", 32'(ch_empty), 32'hF);
      check("rst_err", 32'(err), 32'd0);
      check("rst_acks", 32'({free_ack, rd_ack, wr_ack}), 32'd0);
      rst = 1'b0;
      wait_init();

      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, 1);
         check("t2_wr_addr", 32'(last_wr_addr), i);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 0, 0);
         check("t2_rd_addr", 32'(last_rd_addr), i);
         check("t2_rd_last", 32'(last_rd_last), 32'(i == 2));
      end
      check("t2_ch1_empty", 32'(ch_empty[1]), 32'd1);
      check("t2_free_count", 32'(free_count), 32'd61);

      step(1, 2, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, (i % 2) * 2);
         check("t3_wr_addr", 32'(last_wr_addr), i);
      end
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(1, 2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check("t3_lifo_a", 32'(last_wr_addr), 32'd0);
      step(0, 0, 0, 0, 1, 0);
      check("t3_lifo_b", 32'(last_wr_addr), 32'd2);
      step(0, 0, 1, 2, 0, 0);
      step(0, 0, 1, 2, 0, 0);

      step(0, 0, 0, 0, 1, 1);
      step(1, owned[0], 1, 1, 1, 3);
      check("t5_free_only", 32'({last_free_ack, last_rd_ack, last_wr_ack}), 32'b100);
      step(0, 0, 1, 1, 1, 3);
      check("t5_rd_next", 32'({last_free_ack, last_rd_ack, last_wr_ack}), 32'b010);
      step(0, 0, 1, 1, 1, 3);
      check("t5_wr_last", 32'({last_free_ack, last_rd_ack, last_wr_ack}), 32'b001);

      for (int i = 0; i < 600; i++) begin
         fr = 0;
         fa = 0;
         if (owned.size() > 0 && $urandom_range(0, 3) == 0) begin
            fr = 1;
            fa = owned[$urandom_range(0, owned.size() - 1)];
         end else if (free_q.size() == PAGE_NUM && $urandom_range(0, 7) == 0) begin
            fr = 1;
            fa = int'($urandom_range(0, PAGE_NUM - 1));
         end
         rr = ($urandom_range(0, 9) < 4);
         wr = ($urandom_range(0, 9) < 6);
         rc = int'($urandom_range(0, CH_NUM - 1));
         wc = int'($urandom_range(0, CH_NUM - 1));
         step(fr, fa, rr, rc, wr, wc);
      end

      drain();
      for (int i = 0; i < PAGE_NUM; i++) step(0, 0, 0, 0, 1, i % CH_NUM);
      check("t4_free_empty", 32'(free_empty), 32'd1);
      step(0, 0, 0, 0, 1, 0);
      check("t4_full_wr_ack", 32'(last_wr_ack), 32'd0);
      step(0, 0, 1, 2, 0, 0);
      pg = int'(last_rd_addr);
      step(1, pg, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 3);
      check("t4_realloc", 32'(last_wr_addr), pg);

      drain();
      step(1, 7, 0, 0, 0, 0);
      check("dbl_free_ack", 32'(last_free_ack), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      check("dbl_free_count", 32'(free_count), 32'd64);

      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, i % CH_NUM);
      rst      = 1'b1;
      wr_req   = 1'b1;
      rd_req   = 1'b1;
      rd_ch    = '0;
      free_req = 1'b0;
      @(posedge clk);
      #1;
      check("t6_init_done", 32'(init_done), 32'd0);
      check("t6_acks", 32'({free_ack, rd_ack, wr_ack}), 32'd0);
      rst = 1'b0;
      wait_init();
      step(0, 0, 0, 0, 1, 2);
      check("t6_first_wr", 32'(last_wr_addr), 32'd0);
      step(0, 0, 1, 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
